// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_LEN_W      = 16;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_LEN_LO = 3'd1;
  localparam state_t S_LEN_HI = 3'd2;
  localparam state_t S_DATA   = 3'd3;
  localparam state_t S_CHK    = 3'd4;
  localparam state_t S_DONE   = 3'd5;
  localparam state_t S_ERR    = 3'd6;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic        last_o,
  output logic        valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  idx_q;
  logic [31:0] sr_q;
  logic        valid_q;

  assign last_o  = (idx_q == 2'(BYTES_PER_WORD - 1));
  assign valid_o = valid_q;
  assign word_o  = sr_q;

  // Bytes enter at the top so the first one ends up in [7:0].
  always_ff @(posedge clk_i) begin
    if (!rst_i || clr_i) begin
      idx_q   <= '0;
      sr_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= push_i & last_o;
      if (push_i) begin
        idx_q <= idx_q + 2'd1;
        sr_q  <= {byte_i, sr_q[31:8]};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed image into instruction memory, then releases the CPU.
// Build with IMEM_LOADER_CKSUM_EN to require an XOR checksum trailer byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_data_i,
  output logic              byte_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_data_o,
  output logic              start_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef IMEM_LOADER_CKSUM_EN
  localparam state_t S_POST = S_CHK;
`else
  localparam state_t S_POST = S_DONE;
`endif

  state_t          state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, len_full;
  logic [ADDR_W:0]  wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] addr_q;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]       cks_q, cks_d;
`endif

  logic xfer, pk_clr, pk_push, pk_last, pk_valid, last_word;
  logic [31:0] pk_word;

  assign byte_ready_o = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA) || (state_q == S_CHK);
  assign busy_o   = byte_ready_o;
  assign done_o   = (state_q == S_DONE);
  assign start_o  = done_o;
  assign err_o    = (state_q == S_ERR);

  assign xfer     = byte_valid_i & byte_ready_o;
  assign pk_clr   = (state_q == S_IDLE) & load_i;
  assign pk_push  = xfer & (state_q == S_DATA);
  assign len_full = LEN_W'({byte_data_i, len_q[7:0]});
  assign last_word = (LEN_W'(wcnt_q) + LEN_W'(1)) == len_q;

  word_packer u_packer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (pk_clr),
    .push_i  (pk_push),
    .byte_i  (byte_data_i),
    .last_o  (pk_last),
    .valid_o (pk_valid),
    .word_o  (pk_word)
  );

  assign imem_we_o   = pk_valid;
  assign imem_data_o = pk_word;
  assign imem_addr_o = addr_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
`ifdef IMEM_LOADER_CKSUM_EN
    cks_d   = cks_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (load_i) begin
          state_d = S_LEN_LO;
          len_d   = '0;
          wcnt_d  = '0;
`ifdef IMEM_LOADER_CKSUM_EN
          cks_d   = '0;
`endif
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = byte_data_i;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d = len_full;
          if (32'(len_full) > DEPTH) state_d = S_ERR;
          else if (len_full == '0)   state_d = S_POST;
          else                       state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
`ifdef IMEM_LOADER_CKSUM_EN
          cks_d = cks_q ^ byte_data_i;
`endif
          if (pk_last) begin
            wcnt_d = wcnt_q + 1'b1;
            if (last_word) state_d = S_POST;
          end
        end
      end
`ifdef IMEM_LOADER_CKSUM_EN
      S_CHK: begin
        if (xfer) state_d = (byte_data_i == cks_q) ? S_DONE : S_ERR;
      end
`endif
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      wcnt_q  <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
`ifdef IMEM_LOADER_CKSUM_EN
      cks_q   <= cks_d;
`endif
    end
  end

  // Address advances once the current write pulse has been presented.
  always_ff @(posedge clk_i) begin
    if (!rst_i || pk_clr) addr_q <= '0;
    else if (pk_valid)    addr_q <= addr_q + 1'b1;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader against a stream-level model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        load_i = 1'b0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_data_i = 8'h00;
  logic        byte_ready_o, imem_we_o, start_o, busy_o, done_o, err_o;
  logic [7:0]  imem_addr_o;
  logic [31:0] imem_data_o;

  always #5 clk = ~clk;

  imem_loader dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .load_i       (load_i),
    .byte_valid_i (byte_valid_i),
    .byte_data_i  (byte_data_i),
    .byte_ready_o (byte_ready_o),
    .imem_we_o    (imem_we_o),
    .imem_addr_o  (imem_addr_o),
    .imem_data_o  (imem_data_o),
    .start_o      (start_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  strm[$];
  logic [31:0] words[$];
  int  len, total, n_acc, pend_addr, cyc;
  bit  ok, started, pend;
  logic [31:0] pend_data;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit fin;
    fin = started && (n_acc >= total);
    chk("ready", {31'b0, byte_ready_o}, {31'b0, started && !fin});
    chk("busy",  {31'b0, busy_o},  {31'b0, started && !fin});
    chk("done",  {31'b0, done_o},  {31'b0, fin && ok});
    chk("start", {31'b0, start_o}, {31'b0, fin && ok});
    chk("err",   {31'b0, err_o},   {31'b0, fin && !ok});
    chk("we",    {31'b0, imem_we_o}, {31'b0, pend});
    if (pend) begin
      chk("addr", {24'b0, imem_addr_o}, pend_addr);
      chk("data", imem_data_o, pend_data);
    end
  endtask

  // Stream = length header, payload words LE, optional trailer, junk.
  task automatic build(input int L, input bit bad);
    logic [7:0] x;
    logic [31:0] w;
    x = 8'h00;
    len = L;
    strm = {};
    strm.push_back(8'(L));
    strm.push_back(8'(L >> 8));
    for (int i = 0; i < words.size(); i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        strm.push_back(w[8*b +: 8]);
        x = x ^ w[8*b +: 8];
      end
    end
`ifdef IMEM_LOADER_CKSUM_EN
    strm.push_back(bad ? (x ^ 8'h01) : x);
`endif
    strm.push_back(8'($urandom));
    strm.push_back(8'($urandom));
    if (L > 256) begin
      total = 2;
      ok = 1'b0;
    end else begin
`ifdef IMEM_LOADER_CKSUM_EN
      total = 3 + 4 * L;
      ok = !bad;
`else
      total = 2 + 4 * L;
      ok = 1'b1;
`endif
    end
  endtask

  task automatic rand_words(input int L);
    words = {};
    for (int i = 0; i < L; i++) words.push_back($urandom);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    load_i = 1'b0;
    byte_valid_i = 1'b0;
    @(posedge clk); #1;
    started = 0;
    pend = 0;
    n_acc = 0;
    check_outputs();
    chk("rst_addr", {24'b0, imem_addr_o}, 32'd0);
    chk("rst_data", imem_data_o, 32'd0);
    rst_i = 1'b1;
  endtask

  task automatic start_load();
    load_i = 1'b1;
    @(posedge clk); #1;
    load_i = 1'b0;
    started = 1;
    n_acc = 0;
    pend = 0;
    check_outputs();
  endtask

  task automatic step(input bit vld, input bit ld);
    bit xf;
    int b;
    vld = vld && (n_acc < strm.size());
    byte_valid_i = vld;
    byte_data_i = vld ? strm[n_acc] : 8'($urandom);
    load_i = ld;
    xf = vld && started && (n_acc < total);
    @(posedge clk); #1;
    byte_valid_i = 1'b0;
    load_i = 1'b0;
    pend = 0;
    if (xf) begin
      b = n_acc;
      n_acc++;
      if (b >= 2 && b < 2 + 4 * len && ((b - 2) % 4) == 3) begin
        pend = 1;
        pend_addr = (b - 2) / 4;
        pend_data = words[pend_addr];
      end
    end
    check_outputs();
  endtask

  // mode 0: back-to-back, 1: alternate cycles, 2: random gaps
  task automatic run(input int mode);
    int guard;
    bit v;
    guard = 0;
    cyc = 0;
    while (n_acc < total && guard < 5000) begin
      unique case (mode)
        0: v = 1'b1;
        1: v = cyc[0];
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      step(v, mode == 2 && $urandom_range(0, 7) == 0);
      cyc++;
      guard++;
    end
    chk("timeout", guard, (guard < 5000) ? guard : 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
  endtask

  initial begin
    started = 0;
    pend = 0;
    n_acc = 0;
    total = 0;
    len = 0;
    ok = 1;
    do_reset();
    do_reset();

    words = {32'h00500013, 32'h00A00093};
    build(2, 0);
    start_load();
    run(0);
    do_reset();

    start_load();
    run(1);
    do_reset();

    start_load();
    run(2);
    do_reset();

    words = {};
    build(0, 0);
    start_load();
    run(0);
    do_reset();

    words = {};
    build(257, 0);
    start_load();
    run(2);
    do_reset();

`ifdef IMEM_LOADER_CKSUM_EN
    words = {32'h00500013, 32'h00A00093};
    build(2, 1);
    start_load();
    run(0);
    do_reset();
`endif

    words = {32'h00500013, 32'h00A00093};
    build(2, 0);
    start_load();
    while (n_acc < 8) step(1'b1, 1'b0);
    do_reset();
    start_load();
    run(0);
    do_reset();

    rand_words(256);
    build(256, 0);
    start_load();
    run(0);
    do_reset();

    for (int t = 0; t < 6; t++) begin
      rand_words($urandom_range(1, 8));
      build(words.size(), 0);
      start_load();
      run(2);
      do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
